// File: rtl/regfile_param.sv
// regfile_param: parametrised register file for the richie-jr datapath.
//   DEPTH = 2**ADDR_W registers of WIDTH bits each.
//   Two combinational read ports. One clocked write port that can load,
//   increment or decrement the addressed register. A synchronous clear
//   zeroes the whole file.
//
// Ports:
//   clk      : clock, all state updates on the rising edge
//   res      : asynchronous active-low reset (registers and flags -> 0)
//   clr      : synchronous clear of all registers, active-high, beats wmode
//   wmode    : 00 none, 01 load, 10 increment, 11 decrement
//   waddr    : target register of the write op
//   wdata    : load value (used only for load)
//   raddr_a/b: read addresses
//   rdata_a/b: read data
//   zero     : registered, last write-op result was zero (set by clr)
//   wrap     : registered, last inc/dec wrapped around
//
// Configuration macro: REGFILE_BYPASS_EN
//   defined  : a read that hits the write address shows the next value in
//              the same cycle; clr forces both read ports to 0.
//   undefined: reads always show the stored value.

module regfile_cell #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge res) begin
    if (!res)     q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module regfile_param #(
  parameter int WIDTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              res,
  input  logic              clr,
  input  logic [1:0]        wmode,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [WIDTH-1:0]  rdata_a,
  output logic [WIDTH-1:0]  rdata_b,
  output logic              zero,
  output logic              wrap
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic [1:0] {
    WM_NONE = 2'b00,
    WM_LOAD = 2'b01,
    WM_INC  = 2'b10,
    WM_DEC  = 2'b11
  } wmode_e;

  typedef struct packed {
    wmode_e            mode;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_req_t;

  wr_req_t                      req;
  logic [DEPTH-1:0][WIDTH-1:0]  regs;
  logic [WIDTH-1:0]             cur;
  logic [WIDTH-1:0]             nxt;
  logic                         wr_op;
  logic                         wrap_nxt;

  assign req = '{mode: wmode_e'(wmode), addr: waddr, data: wdata};
  assign cur = regs[req.addr];

  // Next value of the addressed register and its wrap flag.
  always_comb begin
    nxt      = cur;
    wr_op    = 1'b0;
    wrap_nxt = 1'b0;
    case (req.mode)
      WM_LOAD: begin
        nxt   = req.data;
        wr_op = 1'b1;
      end
      WM_INC: begin
        nxt      = cur + WIDTH'(1);
        wr_op    = 1'b1;
        wrap_nxt = &cur;
      end
      WM_DEC: begin
        nxt      = cur - WIDTH'(1);
        wr_op    = 1'b1;
        wrap_nxt = ~|cur;
      end
      default: ;
    endcase
  end

  // One cell per register; clr is applied inside each cell so it wins
  // over the write enable without extra muxing here.
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    regfile_cell #(.WIDTH(WIDTH)) u_cell (
      .clk (clk),
      .res (res),
      .clr (clr),
      .we  (wr_op && (req.addr == ADDR_W'(g))),
      .d   (nxt),
      .q   (regs[g])
    );
  end

  // Flags follow the last write op; idle cycles hold them.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      zero <= 1'b0;
      wrap <= 1'b0;
    end else if (clr) begin
      zero <= 1'b1;
      wrap <= 1'b0;
    end else if (wr_op) begin
      zero <= (nxt == '0);
      wrap <= wrap_nxt;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight result so a same-cycle read sees the new value.
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if (clr) begin
      rdata_a = '0;
      rdata_b = '0;
    end else if (wr_op) begin
      if (raddr_a == req.addr) rdata_a = nxt;
      if (raddr_b == req.addr) rdata_b = nxt;
    end
  end
`else
  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];
`endif

endmodule
